// File: rtl/gerador_quadrado_pkg.sv
// Shared constants, colour type and palette for the bouncing-square generator.
// Palette entries are selected only when GERADOR_QUADRADO_COR_EN is defined.
package gerador_quadrado_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef enum logic {POS, NEG} dir_t;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } cor_t;

    localparam cor_t COR_FUNDO    = '{r: 10'h111, g: 10'h333, b: 10'h777};
    localparam cor_t COR_BRANCO   = '{r: 10'h3FF, g: 10'h3FF, b: 10'h3FF};
    localparam cor_t COR_VERMELHO = '{r: 10'h3FF, g: 10'h000, b: 10'h000};
    localparam cor_t COR_VERDE    = '{r: 10'h000, g: 10'h3FF, b: 10'h000};
    localparam cor_t COR_AMARELO  = '{r: 10'h3FF, g: 10'h3FF, b: 10'h000};

    function automatic cor_t cor_paleta(input logic [1:0] idx);
        cor_t c;
        case (idx)
            2'd0:    c = COR_BRANCO;
            2'd1:    c = COR_VERMELHO;
            2'd2:    c = COR_VERDE;
            default: c = COR_AMARELO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gerador_quadrado_movimento_eixo.sv
// One axis of square motion: position and direction, stepped by VEL on each enabled frame.
// Clamps at 0 and RES-TAM and reverses there; bounce_o flags a reversal (GERADOR_QUADRADO_COR_EN).
module movimento_eixo
    import gerador_quadrado_pkg::*;
#(
    parameter int RES     = 640,
    parameter int TAM     = 200,
    parameter int VEL     = 2,
    parameter int POS_INI = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en_i,
    output logic [9:0] pos_o
`ifdef GERADOR_QUADRADO_COR_EN
    ,
    output logic       bounce_o
`endif
);

    localparam logic [10:0] LIMITE = 11'(RES - TAM);
    localparam logic [10:0] PASSO  = 11'(VEL);

    logic [9:0] pos_q, pos_d;
    dir_t       dir_q, dir_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pos_q <= 10'(POS_INI);
            dir_q <= POS;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    // Compares are done one bit wider so pos+VEL cannot wrap past the limit.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (en_i) begin
            if (dir_q == POS) begin
                if (({1'b0, pos_q} + PASSO) >= LIMITE) begin
                    pos_d = LIMITE[9:0];
                    dir_d = NEG;
                end else begin
                    pos_d = pos_q + PASSO[9:0];
                end
            end else begin
                if ({1'b0, pos_q} <= PASSO) begin
                    pos_d = '0;
                    dir_d = POS;
                end else begin
                    pos_d = pos_q - PASSO[9:0];
                end
            end
        end
    end

    assign pos_o = pos_q;

`ifdef GERADOR_QUADRADO_COR_EN
    assign bounce_o = en_i && (dir_d != dir_q);
`endif

endmodule

// File: rtl/gerador_quadrado.sv
// Bouncing square overlay on a VGA pixel stream; paint and syncs are 1 cycle behind the inputs.
// Optional GERADOR_QUADRADO_COR_EN cycles the square colour on every bounce; no backpressure.
module gerador_quadrado
    import gerador_quadrado_pkg::*;
#(
    parameter int TAM = 200,
    parameter int VEL = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       de_in,
    input  logic       pausa,
    output logic [9:0] paint_r,
    output logic [9:0] paint_g,
    output logic [9:0] paint_b,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       de_out
);

    logic       tick;
    logic       mov_en;
    logic [9:0] pos_x, pos_y;
    logic       dentro;
    cor_t       cor_quad;
    cor_t       cor_d, cor_q;
    logic       hsync_q, vsync_q, de_q;

    // First pixel of the first blanking line: once per frame.
    assign tick   = (sx == 10'd0) && (sy == 10'(V_RES));
    assign mov_en = tick && !pausa;

`ifdef GERADOR_QUADRADO_COR_EN
    logic       bounce_x, bounce_y;
    logic [1:0] idx_q, idx_d;
`endif

    movimento_eixo #(.RES(H_RES), .TAM(TAM), .VEL(VEL), .POS_INI(220)) u_eixo_x (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (mov_en),
        .pos_o   (pos_x)
`ifdef GERADOR_QUADRADO_COR_EN
        ,
        .bounce_o(bounce_x)
`endif
    );

    movimento_eixo #(.RES(V_RES), .TAM(TAM), .VEL(VEL), .POS_INI(140)) u_eixo_y (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (mov_en),
        .pos_o   (pos_y)
`ifdef GERADOR_QUADRADO_COR_EN
        ,
        .bounce_o(bounce_y)
`endif
    );

`ifdef GERADOR_QUADRADO_COR_EN
    // A corner hit reverses both axes but advances the colour only once.
    assign idx_d = idx_q + {1'b0, bounce_x | bounce_y};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign cor_quad = cor_paleta(idx_q);
`else
    assign cor_quad = COR_BRANCO;
`endif

    assign dentro = ({1'b0, sx} >= {1'b0, pos_x}) && ({1'b0, sx} < ({1'b0, pos_x} + 11'(TAM))) &&
                    ({1'b0, sy} >= {1'b0, pos_y}) && ({1'b0, sy} < ({1'b0, pos_y} + 11'(TAM)));

    always_comb begin
        cor_d = '0;
        if (de_in) begin
            cor_d = dentro ? cor_quad : COR_FUNDO;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cor_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
        end else begin
            cor_q   <= cor_d;
            hsync_q <= hsync_in;
            vsync_q <= vsync_in;
            de_q    <= de_in;
        end
    end

    assign paint_r   = cor_q.r;
    assign paint_g   = cor_q.g;
    assign paint_b   = cor_q.b;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign de_out    = de_q;

endmodule

// File: tb/tb_gerador_quadrado.sv
// Bench for gerador_quadrado: vector table, directed motion/bounce/pause/reset sequences,
// then random pixels and frames against a velocity-and-clamp model of the square.
module tb_gerador_quadrado;

    localparam int TAM  = 200;
    localparam int VEL  = 2;
    localparam int XMAX = 640 - TAM;
    localparam int YMAX = 480 - TAM;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] sx = '0, sy = '0;
    logic       hsync_in = 1'b1, vsync_in = 1'b1, de_in = 1'b0, pausa = 1'b0;
    logic [9:0] paint_r, paint_g, paint_b;
    logic       hsync_out, vsync_out, de_out;

    int n_chk = 0;
    int n_err = 0;
    bit chk_model = 1'b0;

    // Model state: top-left corner, signed velocity per axis, bounce count.
    int mpx, mpy, mvx, mvy, mbounces;

    gerador_quadrado #(.TAM(TAM), .VEL(VEL)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .sx       (sx),
        .sy       (sy),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .de_in    (de_in),
        .pausa    (pausa),
        .paint_r  (paint_r),
        .paint_g  (paint_g),
        .paint_b  (paint_b),
        .hsync_out(hsync_out),
        .vsync_out(vsync_out),
        .de_out   (de_out)
    );

    always #20 clock = ~clock;

    function automatic int col(input int r, input int g, input int b);
        return (r << 20) | (g << 10) | b;
    endfunction

    function automatic int pal(input int n);
`ifdef GERADOR_QUADRADO_COR_EN
        case (n % 4)
            0:       return col('h3FF, 'h3FF, 'h3FF);
            1:       return col('h3FF, 'h000, 'h000);
            2:       return col('h000, 'h3FF, 'h000);
            default: return col('h3FF, 'h3FF, 'h000);
        endcase
`else
        return col('h3FF, 'h3FF, 'h3FF) + 0 * n;
`endif
    endfunction

    int WHITE, BG, RED, GREEN;

    function automatic int pix_out();
        return int'({2'b00, paint_r, paint_g, paint_b});
    endfunction

    task automatic chk(input string nome, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    task automatic model_reset();
        mpx = 220; mpy = 140; mvx = VEL; mvy = VEL; mbounces = 0;
    endtask

    task automatic model_tick();
        int nx, ny;
        bit b;
        b  = 1'b0;
        nx = mpx + mvx;
        ny = mpy + mvy;
        if (nx >= XMAX) begin nx = XMAX; mvx = -VEL; b = 1'b1; end
        else if (nx <= 0) begin nx = 0; mvx = VEL; b = 1'b1; end
        if (ny >= YMAX) begin ny = YMAX; mvy = -VEL; b = 1'b1; end
        else if (ny <= 0) begin ny = 0; mvy = VEL; b = 1'b1; end
        mpx = nx;
        mpy = ny;
        if (b) mbounces++;
    endtask

    task automatic drive(input int x, input int y, input bit de, input bit hs, input bit vs,
                         input bit pa, input bit rst);
        int e_pix;
        int e_sync;
        @(negedge clock);
        sx = 10'(x); sy = 10'(y); de_in = de; hsync_in = hs; vsync_in = vs;
        pausa = pa; reset_n = !rst;
        if (rst) begin
            e_pix  = 0;
            e_sync = 6;
        end else begin
            e_sync = (int'(hs) << 2) | (int'(vs) << 1) | int'(de);
            if (!de) e_pix = 0;
            else if (x >= mpx && x < mpx + TAM && y >= mpy && y < mpy + TAM) e_pix = pal(mbounces);
            else e_pix = BG;
        end
        @(posedge clock);
        #1;
        if (chk_model) begin
            chk("rand_pixel", pix_out(), e_pix);
            chk("rand_sync", int'({hsync_out, vsync_out, de_out}), e_sync);
        end
        if (rst) model_reset();
        else if (x == 0 && y == 480 && !pa) model_tick();
    endtask

    task automatic pix(input string nome, input int x, input int y, input int exp);
        drive(x, y, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk(nome, pix_out(), exp);
    endtask

    task automatic ticks(input int n, input bit pa);
        for (int i = 0; i < n; i++) drive(0, 480, 1'b0, 1'b1, 1'b0, pa, 1'b0);
    endtask

    task automatic check_pos(input string nome, input int ex, input int ey, input int c);
        pix({nome, "_corner"}, ex, ey, c);
        pix({nome, "_left"}, ex - 1, ey, BG);
        pix({nome, "_above"}, ex, ey - 1, BG);
        pix({nome, "_far"}, ex + TAM - 1, ey + TAM - 1, c);
        pix({nome, "_right"}, ex + TAM, ey + TAM - 1, BG);
    endtask

    typedef struct {
        int x;
        int y;
        bit de;
        bit hs;
        bit vs;
        int e_pix;
    } vec_t;

    vec_t tab[12];

    initial begin
        WHITE = col('h3FF, 'h3FF, 'h3FF);
        BG    = col('h111, 'h333, 'h777);
        RED   = pal(1);
        GREEN = pal(2);
        model_reset();

        // Reset: held two cycles while inputs try to drive something else.
        drive(300, 200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(300, 200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_paint", pix_out(), 0);
        chk("reset_sync", int'({hsync_out, vsync_out, de_out}), 6);

        tab[0]  = '{300, 200, 1'b1, 1'b1, 1'b1, WHITE};
        tab[1]  = '{100, 200, 1'b1, 1'b1, 1'b1, BG};
        tab[2]  = '{300, 200, 1'b0, 1'b1, 1'b1, 0};
        tab[3]  = '{220, 140, 1'b1, 1'b0, 1'b1, WHITE};
        tab[4]  = '{219, 140, 1'b1, 1'b1, 1'b0, BG};
        tab[5]  = '{220, 139, 1'b1, 1'b0, 1'b0, BG};
        tab[6]  = '{419, 339, 1'b1, 1'b1, 1'b1, WHITE};
        tab[7]  = '{420, 339, 1'b1, 1'b1, 1'b1, BG};
        tab[8]  = '{419, 340, 1'b1, 1'b1, 1'b1, BG};
        tab[9]  = '{1023, 1023, 1'b1, 1'b0, 1'b1, BG};
        tab[10] = '{0, 0, 1'b0, 1'b0, 1'b0, 0};
        tab[11] = '{639, 479, 1'b1, 1'b1, 1'b0, BG};

        for (int i = 0; i < 12; i++) begin
            drive(tab[i].x, tab[i].y, tab[i].de, tab[i].hs, tab[i].vs, 1'b0, 1'b0);
            chk($sformatf("vec%0d_pixel", i), pix_out(), tab[i].e_pix);
            chk($sformatf("vec%0d_sync", i), int'({hsync_out, vsync_out, de_out}),
                (int'(tab[i].hs) << 2) | (int'(tab[i].vs) << 1) | int'(tab[i].de));
        end

        ticks(1, 1'b0);
        pix("tick1_x221", 221, 200, BG);
        pix("tick1_x222", 222, 200, WHITE);
        check_pos("tick1", 222, 142, WHITE);

        ticks(69, 1'b0);
        check_pos("tick70", 360, 280, RED);
        ticks(1, 1'b0);
        check_pos("tick71", 362, 278, RED);

        ticks(39, 1'b0);
        check_pos("tick110", 440, 200, GREEN);
        ticks(1, 1'b0);
        check_pos("tick111", 438, 198, GREEN);

        ticks(5, 1'b1);
        check_pos("paused", 438, 198, GREEN);

        ticks(50, 1'b0);
        drive(0, 480, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("midreset_paint", pix_out(), 0);
        chk("midreset_sync", int'({hsync_out, vsync_out, de_out}), 6);
        check_pos("after_reset", 220, 140, WHITE);
        ticks(1, 1'b0);
        check_pos("after_reset_tick", 222, 142, WHITE);

        chk_model = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            int x, y;
            bit t, rst;
            t   = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 999) == 0);
            x   = t ? 0 : $urandom_range(0, 1023);
            y   = t ? 480 : $urandom_range(0, 1023);
            drive(x, y, 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 4) == 0), rst);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gerador_quadrado.md
GERADOR_QUADRADO -- requirements
Module: gerador_quadrado

Interface
REQ-001 SHALL have parameter TAM, default 200, square side in pixels.
REQ-002 SHALL have parameter VEL, default 2, displacement per axis per frame in pixels.
REQ-003 SHALL have port clock, input, 1, 25 MHz pixel clock; the block uses one clock only.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset sampled on posedge clock.
REQ-005 SHALL have ports sx and sy, input, 10 each, current pixel coordinates from the VGA timing stage.
REQ-006 SHALL have ports hsync_in, vsync_in and de_in, input, 1 each, timing-stage sync and data-enable.
REQ-007 SHALL have port pausa, input, 1, freeze motion while high.
REQ-008 SHALL have ports paint_r, paint_g and paint_b, output, 10 each, pixel colour.
REQ-009 SHALL have ports hsync_out, vsync_out and de_out, output, 1 each, sync and enable delayed to align with paint_*.

Function
REQ-010 SHALL generate frame tick, one cycle wide, when sx==0 and sy==V_RES (first blanking line).
REQ-011 SHALL hold registers pos_x and pos_y (10 bit, square top-left) and one direction state per axis, POS or NEG.
REQ-012 SHALL, on tick with pausa=0 and direction POS: if pos+VEL >= RES-TAM, set pos=RES-TAM and direction NEG; otherwise add VEL to pos.
REQ-013 SHALL, on tick with pausa=0 and direction NEG: if pos <= VEL, set pos=0 and direction POS; otherwise subtract VEL from pos.
REQ-014 SHALL leave position and direction unchanged on tick with pausa=1 and on every non-tick cycle.
REQ-015 SHALL define inside as pos_x <= sx < pos_x+TAM and pos_y <= sy < pos_y+TAM, using 11-bit compares with no wrap.
REQ-016 SHALL register paint_* with 1-cycle latency: de_in=0 gives 0; inside gives square colour; outside gives background 10'h111/10'h333/10'h777.
REQ-017 SHALL delay hsync_in, vsync_in and de_in by exactly 1 cycle to produce hsync_out, vsync_out and de_out.
REQ-018 SHALL treat a bounce on X and Y in the same tick (corner) as one bounce event.

Reset
REQ-019 SHALL, while reset_n=0 at posedge, set paint_* to 0, hsync_out and vsync_out to 1, de_out to 0, pos to (220,140), both directions to POS and colour index to 0.
REQ-020 SHALL ignore a frame tick coincident with reset; reset mid-frame takes effect on the next edge with no partial update.

Configuration
REQ-021 SHALL use macro GERADOR_QUADRADO_COR_EN.
REQ-022 SHALL, with GERADOR_QUADRADO_COR_EN defined, advance a 2-bit colour index once per bounce event (wrapping 3->0); palette is white 3FF/3FF/3FF, red 3FF/000/000, green 000/3FF/000, yellow 3FF/3FF/000.
REQ-023 SHALL, without GERADOR_QUADRADO_COR_EN, use a fixed square colour of 3FF/3FF/3FF and contain no index register.

Structure
REQ-024 SHALL place H_RES=640, V_RES=480, the background and palette constants and typedef enum dir_t {POS,NEG} in package gerador_quadrado_pkg.
REQ-025 SHALL implement per-axis position and direction logic in sub-module movimento_eixo, parameterised by RES, and instantiate it twice.

Verification
REQ-026 SHALL cover reset: reset_n=0 for 2 cycles -> paint_*=0, hsync_out=vsync_out=1, de_out=0, pos=(220,140).
REQ-027 SHALL cover colour: after reset with de_in=1, sx=300, sy=200 -> paint_*=3FF next cycle; sx=100 -> 111/333/777; de_in=0 -> 0.
REQ-028 SHALL cover motion: 1 tick -> pos=(222,142); sx=221, sy=200 -> background, sx=222 -> square.
REQ-029 SHALL cover bounce: 70 ticks -> pos_y=280 with Y direction NEG; 110 ticks -> pos_x=440 with X direction NEG; tick 111 -> pos_x=438; with GERADOR_QUADRADO_COR_EN, colour red after tick 70 and green after tick 110.
REQ-030 SHALL cover pause: pausa=1 across 5 ticks -> pos unchanged and colour index unchanged.
REQ-031 SHALL cover reset mid-operation: 50 ticks, then reset_n=0 for one cycle -> pos=(220,140), directions POS, colour index 0.
